// File: rtl/phy_clock_ctrl.sv
// Ethernet PHY clock PLL controller: PLL reset/lock sequencing, PHY reset,
// and glitch-free TX clock selection by gating clk_en around each switch.
`timescale 1ns/1ps
module phy_clock_ctrl #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int LOCK_STABLE    = 1024,
   parameter int PHY_RST_CYCLES = 500000,
   parameter int SWITCH_GAP     = 8,
   parameter int MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic [1:0] speed,
   output logic       pll_rst,
   output logic       phy_rst_n,
   output logic       clk_en,
   output logic [1:0] clk_sel,
   output logic       ready,
   output logic       fail,
   output logic [1:0] retry_cnt
);

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXP = imax(imax(imax(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                   imax(LOCK_STABLE, PHY_RST_CYCLES)),
                              2 * SWITCH_GAP);
   localparam int CW = $clog2(MAXP + 1);

   localparam logic [CW-1:0] T_PLL  = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] T_LOCK = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] T_STAB = CW'(LOCK_STABLE - 1);
   localparam logic [CW-1:0] T_PHY  = CW'(PHY_RST_CYCLES - 1);
   localparam logic [CW-1:0] T_GAP1 = CW'(SWITCH_GAP - 1);
   localparam logic [CW-1:0] T_GAP2 = CW'(2 * SWITCH_GAP - 1);
   localparam logic [1:0]    MR     = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RST_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_PHY_RST,
      S_RUN,
      S_SWITCH,
      S_FAIL
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [1:0]    retry_q, retry_d;
   logic          pll_rst_q, pll_rst_d;
   logic          phy_rst_n_q, phy_rst_n_d;
   logic          clk_en_q, clk_en_d;
   logic [1:0]    clk_sel_q, clk_sel_d;
   logic          ready_q, ready_d;
   logic          fail_q, fail_d;
   logic          phy_done_q, phy_done_d;

   logic          lk1_q, lk2_q;
   logic [1:0]    sp1_q, sp2_q;
   logic          locked_s;
   logic [1:0]    speed_n;

   assign locked_s = lk2_q;
   // Reserved speed code 11 runs at the 10M rate.
   assign speed_n  = (sp2_q == 2'b11) ? 2'b00 : sp2_q;
   assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk1_q <= 1'b0;
         lk2_q <= 1'b0;
         sp1_q <= 2'b00;
         sp2_q <= 2'b00;
      end else begin
         lk1_q <= pll_locked;
         lk2_q <= lk1_q;
         sp1_q <= speed;
         sp2_q <= sp1_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_inc;
      retry_d     = retry_q;
      pll_rst_d   = pll_rst_q;
      phy_rst_n_d = phy_rst_n_q;
      clk_en_d    = clk_en_q;
      clk_sel_d   = clk_sel_q;
      ready_d     = ready_q;
      fail_d      = fail_q;
      phy_done_d  = phy_done_q;
      unique case (state_q)
         S_RST_PLL: begin
            pll_rst_d = 1'b1;
            if (cnt_q == T_PLL) begin
               state_d   = S_WAIT_LOCK;
               pll_rst_d = 1'b0;
               cnt_d     = '0;
            end
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == T_LOCK) begin
               cnt_d = '0;
               if (retry_q < MR) begin
                  state_d   = S_RST_PLL;
                  retry_d   = retry_q + 2'd1;
                  pll_rst_d = 1'b1;
               end else begin
                  state_d     = S_FAIL;
                  fail_d      = 1'b1;
                  phy_rst_n_d = 1'b0;
               end
            end
         end
         S_STABLE: begin
            if (!locked_s) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == T_STAB) begin
               cnt_d = '0;
               if (phy_done_q) begin
                  state_d   = S_RUN;
                  clk_sel_d = speed_n;
                  clk_en_d  = 1'b1;
                  ready_d   = 1'b1;
                  retry_d   = 2'd0;
               end else begin
                  state_d = S_PHY_RST;
               end
            end
         end
         S_PHY_RST: begin
            if (cnt_q == T_PHY) begin
               state_d     = S_RUN;
               phy_rst_n_d = 1'b1;
               phy_done_d  = 1'b1;
               clk_sel_d   = speed_n;
               clk_en_d    = 1'b1;
               ready_d     = 1'b1;
               retry_d     = 2'd0;
               cnt_d       = '0;
            end
         end
         S_RUN: begin
            if (!locked_s) begin
               state_d   = S_RST_PLL;
               clk_en_d  = 1'b0;
               ready_d   = 1'b0;
               pll_rst_d = 1'b1;
               cnt_d     = '0;
            end else if (speed_n != clk_sel_q) begin
               state_d  = S_SWITCH;
               clk_en_d = 1'b0;
               ready_d  = 1'b0;
               cnt_d    = '0;
            end
         end
         S_SWITCH: begin
            if (!locked_s) begin
               state_d   = S_RST_PLL;
               clk_en_d  = 1'b0;
               ready_d   = 1'b0;
               pll_rst_d = 1'b1;
               cnt_d     = '0;
            end else begin
               if (cnt_q == T_GAP1)
                  clk_sel_d = speed_n;
               if (cnt_q == T_GAP2) begin
                  state_d  = S_RUN;
                  clk_en_d = 1'b1;
                  ready_d  = 1'b1;
               end
            end
         end
         S_FAIL: begin
            cnt_d       = cnt_q;
            pll_rst_d   = 1'b0;
            phy_rst_n_d = 1'b0;
            clk_en_d    = 1'b0;
            ready_d     = 1'b0;
            fail_d      = 1'b1;
         end
         default: begin
            state_d = S_RST_PLL;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RST_PLL;
         cnt_q       <= '0;
         retry_q     <= 2'd0;
         pll_rst_q   <= 1'b1;
         phy_rst_n_q <= 1'b0;
         clk_en_q    <= 1'b0;
         clk_sel_q   <= 2'b10;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
         phy_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_rst_q   <= pll_rst_d;
         phy_rst_n_q <= phy_rst_n_d;
         clk_en_q    <= clk_en_d;
         clk_sel_q   <= clk_sel_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
         phy_done_q  <= phy_done_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign phy_rst_n = phy_rst_n_q;
   assign clk_en    = clk_en_q;
   assign clk_sel   = clk_sel_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_phy_clock_ctrl.sv
// Bench for phy_clock_ctrl: timeline model predicts output-change events,
// a negedge monitor matches every DUT output change against the queue.
`timescale 1ns/1ps
module tb_phy_clock_ctrl;

   localparam int PR = 4;
   localparam int LT = 100;
   localparam int LS = 8;
   localparam int PH = 20;
   localparam int SG = 3;
   localparam int MR = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_locked = 1'b0;
   logic [1:0] speed = 2'b10;
   logic       pll_rst, phy_rst_n, clk_en, ready, fail;
   logic [1:0] clk_sel, retry_cnt;

   always #5 clk = ~clk;

   phy_clock_ctrl #(
      .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS),
      .PHY_RST_CYCLES(PH), .SWITCH_GAP(SG), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .speed(speed),
      .pll_rst(pll_rst), .phy_rst_n(phy_rst_n), .clk_en(clk_en),
      .clk_sel(clk_sel), .ready(ready), .fail(fail),
      .retry_cnt(retry_cnt)
   );

   typedef struct packed {
      logic       pll_rst;
      logic       phy_rst_n;
      logic       clk_en;
      logic [1:0] clk_sel;
      logic       ready;
      logic       fail;
      logic [1:0] retry;
   } obs_t;

   typedef struct {
      obs_t o;
      int   t;
      int   tol;
   } ev_t;

   localparam obs_t RST_O = '{pll_rst: 1'b1, phy_rst_n: 1'b0, clk_en: 1'b0,
                              clk_sel: 2'b10, ready: 1'b0, fail: 1'b0,
                              retry: 2'b00};

   ev_t  sbq[$];
   obs_t exp_o;
   obs_t prev;
   int   cyc;
   int   n_vec;
   int   n_err;
   bit   mon_en;

   function automatic obs_t dut_o();
      obs_t r;
      r = {pll_rst, phy_rst_n, clk_en, clk_sel, ready, fail, retry_cnt};
      return r;
   endfunction

   function automatic logic [1:0] norm(input logic [1:0] s);
      return (s == 2'b11) ? 2'b00 : s;
   endfunction

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   always @(negedge clk) begin
      obs_t cur;
      ev_t  e;
      cur = dut_o();
      if (mon_en && cur !== prev) begin
         if (cur.clk_sel !== prev.clk_sel) begin
            n_vec++;
            if (prev.clk_en !== 1'b0) begin
               n_err++;
               $display("FAIL sel_while_en cyc=%0d sel %b->%b clk_en=%b, required clk_en=0",
                        cyc, prev.clk_sel, cur.clk_sel, prev.clk_en);
            end
         end
         n_vec++;
         if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change cyc=%0d got %b, required unchanged %b",
                     cyc, cur, prev);
         end else begin
            e = sbq.pop_front();
            if (cur !== e.o || cyc < e.t - e.tol || cyc > e.t + e.tol) begin
               n_err++;
               $display("FAIL event cyc=%0d got %b, required %b at cyc %0d+-%0d",
                        cyc, cur, e.o, e.t, e.tol);
            end
         end
      end
      prev = cur;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic tick_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic push(input int t, input int tol);
      ev_t e;
      e.o   = exp_o;
      e.t   = t;
      e.tol = tol;
      sbq.push_back(e);
   endtask

   task automatic check_now(input string nm);
      n_vec++;
      if (dut_o() !== exp_o) begin
         n_err++;
         $display("FAIL %s cyc=%0d got %b, required %b", nm, cyc, dut_o(), exp_o);
      end
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (sbq.size() != 0 && k < 3000) begin
         tick();
         k++;
      end
      n_vec++;
      if (sbq.size() != 0) begin
         n_err++;
         $display("FAIL %s_timeout cyc=%0d pending=%0d, required 0",
                  nm, cyc, sbq.size());
         sbq.delete();
      end
      repeat (4) tick();
      check_now(nm);
   endtask

   task automatic release_rst();
      pll_locked = 1'b0;
      repeat (2) tick();
      rst_n  = 1'b1;
      cyc    = 0;
      exp_o  = RST_O;
      mon_en = 1'b1;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      sbq.delete();
      repeat (3) tick();
      n_vec++;
      if (dut_o() !== RST_O) begin
         n_err++;
         $display("FAIL reset_vals got %b, required %b", dut_o(), RST_O);
      end
      release_rst();
   endtask

   task automatic mid_reset(input string nm);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      n_vec++;
      if (dut_o() !== RST_O) begin
         n_err++;
         $display("FAIL %s got %b, required %b", nm, dut_o(), RST_O);
      end
      sbq.delete();
      release_rst();
   endtask

   task automatic bring_up(input int a, input int loff, input int g,
                           input bit drain_it);
      int w, l, lp;
      exp_o.pll_rst = 1'b0;
      push(PR, 0);
      for (int i = 0; i < a; i++) begin
         w = PR + i * (PR + LT);
         exp_o.pll_rst = 1'b1;
         exp_o.retry   = 2'(i + 1);
         push(w + LT, 1);
         exp_o.pll_rst = 1'b0;
         push(w + LT + PR, 1);
      end
      w  = PR + a * (PR + LT);
      l  = w + loff;
      lp = (g != 0) ? l + g + 1 : l;
      exp_o.phy_rst_n = 1'b1;
      exp_o.clk_en    = 1'b1;
      exp_o.clk_sel   = norm(speed);
      exp_o.ready     = 1'b1;
      exp_o.retry     = 2'b00;
      push(lp + 3 + LS + PH, 1);
      tick_to(l);
      pll_locked = 1'b1;
      if (g != 0) begin
         tick_to(l + g);
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
      end
      if (drain_it) drain("bringup");
   endtask

   task automatic sched(input int t, input logic [1:0] sel);
      exp_o.clk_en  = 1'b0;
      exp_o.ready   = 1'b0;
      push(t, 0);
      exp_o.clk_sel = sel;
      push(t + SG, 0);
      exp_o.clk_en  = 1'b1;
      exp_o.ready   = 1'b1;
      push(t + 2 * SG, 0);
   endtask

   task automatic do_switch(input logic [1:0] v, input bit inner);
      int s, st, d;
      logic [1:0] v2;
      s = cyc;
      speed = v;
      if (norm(v) == exp_o.clk_sel) begin
         repeat (12) tick();
         check_now("noswitch");
         return;
      end
      sched(s + 3, norm(v));
      if (inner) begin
         v2 = 2'($urandom_range(0, 3));
         if (norm(v2) == norm(v))
            v2 = (norm(v) == 2'b01) ? 2'b10 : 2'b01;
         d = $urandom_range(0, 2);
         tick_to(s + 3 + SG + d);
         speed = v2;
         st = imax(s + 3 + 2 * SG + 1, s + 3 + SG + d + 3);
         sched(st, norm(v2));
      end
      drain("switch");
   endtask

   task automatic lose_lock(input int r, input logic [1:0] nv);
      int d, l, entry;
      d = cyc;
      pll_locked = 1'b0;
      exp_o.clk_en  = 1'b0;
      exp_o.ready   = 1'b0;
      exp_o.pll_rst = 1'b1;
      push(d + 3, 0);
      exp_o.pll_rst = 1'b0;
      push(d + 3 + PR, 0);
      tick();
      speed = nv;
      l = d + r;
      entry = imax(d + 3 + PR + 1, l + 3);
      exp_o.clk_en  = 1'b1;
      exp_o.ready   = 1'b1;
      exp_o.clk_sel = norm(nv);
      exp_o.retry   = 2'b00;
      push(entry + LS, 1);
      tick_to(l);
      pll_locked = 1'b1;
      drain("relock");
   endtask

   task automatic retries_exhausted();
      int w;
      exp_o.pll_rst = 1'b0;
      push(PR, 0);
      for (int i = 0; i < MR; i++) begin
         w = PR + i * (PR + LT);
         exp_o.pll_rst = 1'b1;
         exp_o.retry   = 2'(i + 1);
         push(w + LT, 1);
         exp_o.pll_rst = 1'b0;
         push(w + LT + PR, 1);
      end
      w = PR + MR * (PR + LT);
      exp_o.fail = 1'b1;
      push(w + LT, 1);
      drain("fail");
      repeat (150) tick();
      check_now("fail_sticky");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec  = 0;
      n_err  = 0;
      cyc    = 0;
      mon_en = 1'b0;
      exp_o  = RST_O;
      do_reset();
      bring_up(0, 16, 0, 1);
      do_switch(2'b01, 1'b0);
      do_switch(2'b11, 1'b0);
      do_switch(2'b10, 1'b1);
      repeat (8) do_switch(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      lose_lock(1, speed);
      lose_lock($urandom_range(2, 40), 2'($urandom_range(0, 3)));
      do_switch(2'($urandom_range(0, 3)), 1'b1);
      repeat (5) tick();
      mid_reset("reset_in_run");
      retries_exhausted();
      do_reset();
      speed = 2'b01;
      bring_up(1, 10, 5, 1'b0);
      tick_to(145);
      mid_reset("reset_in_phy_rst");
      speed = 2'b10;
      bring_up(0, 16, 5, 1'b1);
      do_reset();
      speed = 2'($urandom_range(0, 3));
      bring_up($urandom_range(0, 2), $urandom_range(0, 60),
               $urandom_range(0, 8), 1'b1);
      repeat (4) do_switch(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      lose_lock($urandom_range(1, 40), 2'($urandom_range(0, 3)));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
